decode_issue_stage: RTL and testbench

Parametrised successor of the decode stage. Adds a registered decode/issue output with valid/ready handshakes, real load-use stalling, and forwarding from N bypass sources plus same-cycle writeback. Sits between fetch and execute, owns the `register_file` instance and emits `inst_decoded_t` to execute.

---
 rtl/constants_pkg.sv | 8 +
 rtl/instruction_pkg.sv | 37 +++
 rtl/operand_forward.sv | 44 ++++
 rtl/register_file.sv | 32 +++
 rtl/decode_issue_stage.sv | 164 ++++++++++++++++
 tb/tb_decode_issue_stage.sv | 215 +++++++++++++++++++++
 6 files changed

// File: rtl/constants_pkg.sv
// Architectural constants shared by the decode slice.
// Holds register count, instruction and data widths.
package constants_pkg;
  localparam int REG_FILE_LEN = 32;
  localparam int INST_LEN     = 32;
  localparam int ARCH_LEN     = 32;
  localparam int REG_ADDR_W   = $clog2(REG_FILE_LEN);
endpackage

// File: rtl/instruction_pkg.sv
// Decoded-instruction bundle, RV32I opcodes and decode FSM states.
// Shared by decode_issue_stage, operand_forward and the bench.
package instruction_pkg;
  import constants_pkg::*;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef struct packed {
    logic                  valid;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [REG_ADDR_W-1:0] src_reg_1;
    logic [REG_ADDR_W-1:0] src_reg_2;
    logic [REG_ADDR_W-1:0] dst_reg;
    logic [ARCH_LEN-1:0]   src_data_1;
    logic [ARCH_LEN-1:0]   src_data_2;
    logic [ARCH_LEN-1:0]   imm;
    logic                  reg_write_enable;
    logic                  reg_data_ready;
    logic [ARCH_LEN-1:0]   dst_reg_data;
  } inst_decoded_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2
  } dec_state_t;
endpackage

// File: rtl/operand_forward.sv
// Priority operand mux for one source: bypass[0..N-1], then wb, then RF.
// Ports: rs_in, use_in, bypass_in, wb_in, rf_data_in -> data_out, hazard_out.
module operand_forward
  import constants_pkg::*;
  import instruction_pkg::*;
#(
  parameter int NUM_BYPASS = 2
) (
  input  logic [REG_ADDR_W-1:0]            rs_in,
  input  logic                             use_in,
  input  inst_decoded_t [NUM_BYPASS-1:0]   bypass_in,
  input  inst_decoded_t                    wb_in,
  input  logic [ARCH_LEN-1:0]              rf_data_in,
  output logic [ARCH_LEN-1:0]              data_out,
  output logic                             hazard_out
);
  logic live;
  logic found;
  logic unused_bits;

  assign live = use_in & (rs_in != '0);
  assign unused_bits = ^{bypass_in, wb_in};

  always_comb begin
    data_out   = rf_data_in;
    hazard_out = 1'b0;
    found      = 1'b0;
    if (live && wb_in.valid && wb_in.reg_write_enable &&
        wb_in.dst_reg == rs_in)
      data_out = wb_in.dst_reg_data;
    // youngest matching producer decides; older ones are ignored
    for (int i = 0; i < NUM_BYPASS; i++) begin
      if (!found && live && bypass_in[i].valid &&
          bypass_in[i].reg_write_enable &&
          bypass_in[i].dst_reg == rs_in) begin
        found = 1'b1;
        if (bypass_in[i].reg_data_ready)
          data_out = bypass_in[i].dst_reg_data;
        else
          hazard_out = 1'b1;
      end
    end
  end
endmodule

// File: rtl/register_file.sv
// Architectural register file: one write port, two async read ports.
// Ports: clk, rst (async low), wr_en/addr/data, rd_addr_1/2 -> rd_data_1/2.
module register_file
  import constants_pkg::*;
#(
  parameter int REG_FILE_LEN = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [ARCH_LEN-1:0]   wr_data,
  input  logic [REG_ADDR_W-1:0] rd_addr_1,
  output logic [ARCH_LEN-1:0]   rd_data_1,
  input  logic [REG_ADDR_W-1:0] rd_addr_2,
  output logic [ARCH_LEN-1:0]   rd_data_2
);
  logic [ARCH_LEN-1:0] mem_q [REG_FILE_LEN];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_FILE_LEN; i++)
        mem_q[i] <= '0;
    end else if (wr_en && wr_addr != '0) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // x0 is hardwired to zero regardless of array contents
  assign rd_data_1 = (rd_addr_1 == '0) ? '0 : mem_q[rd_addr_1];
  assign rd_data_2 = (rd_addr_2 == '0) ? '0 : mem_q[rd_addr_2];
endmodule

// File: rtl/decode_issue_stage.sv
// RV32I decode/issue stage with registered output, forwarding, load-use stall.
// Ports: fetch valid/ready in, inst_dec_out valid/ready out, wb, bypass, stall.
// Optional: DECODE_STALL_CNT_EN builds the saturating stall_cycles_out counter.
module decode_issue_stage
  import constants_pkg::*;
  import instruction_pkg::*;
#(
  parameter int NUM_BYPASS   = 2,
  parameter int REG_FILE_LEN = 32,
  parameter int STALL_CNT_W  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush_in,
  input  logic                           inst_valid_in,
  output logic                           inst_ready_out,
  input  logic [INST_LEN-1:0]            inst_fetched_in,
  output inst_decoded_t                  inst_dec_out,
  input  logic                           dec_ready_in,
  input  inst_decoded_t                  inst_wb_in,
  input  inst_decoded_t [NUM_BYPASS-1:0] bypass_in,
  output logic                           stall_dec_out,
  output logic [STALL_CNT_W-1:0]         stall_cycles_out
);
  inst_decoded_t dec;
  inst_decoded_t out_q, out_d;
  dec_state_t    state_q, state_d;

  logic [6:0] op;
  logic is_r, is_i, is_s, is_b, is_u, is_j;
  logic use1, use2;
  logic [ARCH_LEN-1:0] rf1, rf2, fw1, fw2;
  logic haz1, haz2, slot1, slot2;
  logic hazard, accept;
  logic [INST_LEN-1:0] ins;

  assign ins = inst_fetched_in;
  assign op  = ins[6:0];
  assign is_r = op == OP_R;
  assign is_i = op == OP_IMM || op == OP_LOAD || op == OP_JALR;
  assign is_s = op == OP_STORE;
  assign is_b = op == OP_BR;
  assign is_u = op == OP_LUI || op == OP_AUIPC;
  assign is_j = op == OP_JAL;
  assign use1 = is_r | is_i | is_s | is_b;
  assign use2 = is_r | is_s | is_b;

  register_file #(
    .REG_FILE_LEN(REG_FILE_LEN)
  ) u_rf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (inst_wb_in.valid & inst_wb_in.reg_write_enable),
    .wr_addr   (inst_wb_in.dst_reg),
    .wr_data   (inst_wb_in.dst_reg_data),
    .rd_addr_1 (ins[19:15]),
    .rd_data_1 (rf1),
    .rd_addr_2 (ins[24:20]),
    .rd_data_2 (rf2)
  );

  operand_forward #(.NUM_BYPASS(NUM_BYPASS)) u_fw1 (
    .rs_in      (ins[19:15]),
    .use_in     (use1),
    .bypass_in  (bypass_in),
    .wb_in      (inst_wb_in),
    .rf_data_in (rf1),
    .data_out   (fw1),
    .hazard_out (haz1)
  );

  operand_forward #(.NUM_BYPASS(NUM_BYPASS)) u_fw2 (
    .rs_in      (ins[24:20]),
    .use_in     (use2),
    .bypass_in  (bypass_in),
    .wb_in      (inst_wb_in),
    .rf_data_in (rf2),
    .data_out   (fw2),
    .hazard_out (haz2)
  );

  always_comb begin
    dec = '0;
    dec.opcode     = op;
    dec.funct3     = ins[14:12];
    dec.funct7     = ins[31:25];
    dec.src_reg_1  = ins[19:15];
    dec.src_reg_2  = ins[24:20];
    dec.dst_reg    = ins[11:7];
    dec.src_data_1 = fw1;
    dec.src_data_2 = fw2;
    dec.reg_write_enable = (is_r | is_i | is_u | is_j) & (ins[11:7] != '0);
    unique case (1'b1)
      is_i: dec.imm = {{20{ins[31]}}, ins[31:20]};
      is_s: dec.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      is_b: dec.imm = {{19{ins[31]}}, ins[31], ins[7],
                       ins[30:25], ins[11:8], 1'b0};
      is_u: dec.imm = {ins[31:12], 12'b0};
      is_j: dec.imm = {{11{ins[31]}}, ins[31], ins[19:12],
                       ins[20], ins[30:21], 1'b0};
      default: dec.imm = '0;
    endcase
  end

  // The producer sitting in the output slot has no result yet
  assign slot1 = use1 && ins[19:15] != '0 && out_q.valid &&
                 out_q.reg_write_enable && out_q.dst_reg == ins[19:15];
  assign slot2 = use2 && ins[24:20] != '0 && out_q.valid &&
                 out_q.reg_write_enable && out_q.dst_reg == ins[24:20];

  assign hazard = haz1 | haz2 | slot1 | slot2;
  assign inst_ready_out = ~hazard & (~out_q.valid | dec_ready_in) & ~flush_in;
  assign accept = inst_valid_in & inst_ready_out;
  assign stall_dec_out = inst_valid_in & hazard;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    if (flush_in) begin
      state_d = IDLE;
      out_d   = '0;
    end else if (accept) begin
      state_d = ISSUE;
      out_d = dec;
      out_d.valid = 1'b1;
    end else if (out_q.valid && !dec_ready_in) begin
      state_d = ISSUE;
    end else begin
      out_d.valid = 1'b0;
      state_d = (inst_valid_in && hazard) ? STALL : IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign inst_dec_out = out_q;

`ifdef DECODE_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (stall_dec_out && !(&cnt_q))
      cnt_d = cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign stall_cycles_out = cnt_q;
`else
  assign stall_cycles_out = '0;
`endif
endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: forwarding, stalls, flush,
// backpressure and reset, with hand-computed expected values.
module tb_decode_issue_stage;
  import constants_pkg::*;
  import instruction_pkg::*;

  localparam logic [31:0] ADDI_X1 = 32'h00500093;
  localparam logic [31:0] ADD_X2  = 32'h00108133;
  localparam logic [31:0] ADDI_X5 = 32'h00018293;
  localparam logic [31:0] ADDI_X6 = 32'h00020313;
  localparam logic [31:0] ADD_X7  = 32'h000003B3;
  localparam logic [31:0] ADDI_X8 = 32'hFFF00413;
  localparam logic [31:0] LUI_X9  = 32'h123454B7;
`ifdef DECODE_STALL_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst, flush_in, inst_valid_in, inst_ready_out;
  logic dec_ready_in, stall_dec_out;
  logic [INST_LEN-1:0] inst_fetched_in;
  inst_decoded_t inst_dec_out, inst_wb_in;
  inst_decoded_t [1:0] bypass_in;
  logic [31:0] stall_cycles_out;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_issue_stage #(
    .NUM_BYPASS(2), .REG_FILE_LEN(32), .STALL_CNT_W(32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .flush_in         (flush_in),
    .inst_valid_in    (inst_valid_in),
    .inst_ready_out   (inst_ready_out),
    .inst_fetched_in  (inst_fetched_in),
    .inst_dec_out     (inst_dec_out),
    .dec_ready_in     (dec_ready_in),
    .inst_wb_in       (inst_wb_in),
    .bypass_in        (bypass_in),
    .stall_dec_out    (stall_dec_out),
    .stall_cycles_out (stall_cycles_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic inst_decoded_t byp(logic [4:0] r, logic rdy,
                                        logic [31:0] d);
    byp = '0;
    byp.valid = 1'b1;
    byp.reg_write_enable = 1'b1;
    byp.dst_reg = r;
    byp.reg_data_ready = rdy;
    byp.dst_reg_data = d;
  endfunction

  initial begin
    rst = 1'b0;
    flush_in = 1'b0;
    inst_valid_in = 1'b1;
    inst_fetched_in = ADD_X2;
    dec_ready_in = 1'b1;
    inst_wb_in = '0;
    bypass_in = '0;
    tick();
    tick();
    chk("rst_valid", 32'(inst_dec_out.valid), 0);
    chk("rst_cnt", stall_cycles_out, 0);
    chk("rst_ready", 32'(inst_ready_out), 1);
    chk("rst_stall", 32'(stall_dec_out), 0);
    inst_valid_in = 1'b0;
    rst = 1'b1;

    inst_fetched_in = ADDI_X1;
    inst_valid_in = 1'b1;
    #1 chk("addi_ready", 32'(inst_ready_out), 1);
    tick();
    chk("addi_valid", 32'(inst_dec_out.valid), 1);
    chk("addi_imm", inst_dec_out.imm, 5);
    chk("addi_rd", 32'(inst_dec_out.dst_reg), 1);
    chk("addi_we", 32'(inst_dec_out.reg_write_enable), 1);
    inst_fetched_in = ADD_X2;
    #1 chk("raw_stall", 32'(stall_dec_out), 1);
    chk("raw_ready", 32'(inst_ready_out), 0);
    tick();
    chk("bubble_valid", 32'(inst_dec_out.valid), 0);
    bypass_in[0] = byp(5'd1, 1'b1, 32'd5);
    #1 chk("raw_clear", 32'(stall_dec_out), 0);
    tick();
    chk("add_valid", 32'(inst_dec_out.valid), 1);
    chk("add_s1", inst_dec_out.src_data_1, 5);
    chk("add_s2", inst_dec_out.src_data_2, 5);
    chk("add_rd", 32'(inst_dec_out.dst_reg), 2);

    bypass_in[0] = byp(5'd1, 1'b0, 32'd0);
    #1 chk("nr_stall", 32'(stall_dec_out), 1);
    tick();
    chk("stall_state", 32'(dut.state_q), 32'(STALL));
    chk("stall_bubble", 32'(inst_dec_out.valid), 0);
    rst = 1'b0;
    bypass_in = '0;
    #1;
    chk("mrst_valid", 32'(inst_dec_out.valid), 0);
    chk("mrst_cnt", stall_cycles_out, 0);
    chk("mrst_ready", 32'(inst_ready_out), 1);
    chk("mrst_stall", 32'(stall_dec_out), 0);
    chk("mrst_state", 32'(dut.state_q), 32'(IDLE));
    inst_valid_in = 1'b0;
    tick();
    rst = 1'b1;

    inst_fetched_in = ADDI_X5;
    inst_valid_in = 1'b1;
    bypass_in[1] = byp(5'd3, 1'b0, 32'd0);
    #1 chk("lu_stall0", 32'(stall_dec_out), 1);
    tick();
    chk("lu_stall1", 32'(stall_dec_out), 1);
    tick();
    bypass_in[1] = byp(5'd3, 1'b1, 32'hDEAD);
    #1 chk("lu_clear", 32'(stall_dec_out), 0);
    tick();
    chk("lu_valid", 32'(inst_dec_out.valid), 1);
    chk("lu_s1", inst_dec_out.src_data_1, 32'hDEAD);
    chk("lu_cnt", stall_cycles_out, 32'(2 * CNT_ON));

    bypass_in[0] = byp(5'd4, 1'b1, 32'h11);
    bypass_in[1] = byp(5'd4, 1'b1, 32'h22);
    inst_wb_in = byp(5'd4, 1'b1, 32'h33);
    inst_fetched_in = ADDI_X6;
    tick();
    chk("pri_b0", inst_dec_out.src_data_1, 32'h11);
    bypass_in[0] = '0;
    tick();
    chk("pri_b1", inst_dec_out.src_data_1, 32'h22);
    bypass_in[1] = '0;
    tick();
    chk("pri_wb", inst_dec_out.src_data_1, 32'h33);
    inst_wb_in = '0;
    tick();
    chk("pri_rf", inst_dec_out.src_data_1, 32'h33);
    bypass_in[0] = byp(5'd4, 1'b0, 32'd0);
    bypass_in[1] = byp(5'd4, 1'b1, 32'h22);
    #1 chk("pri_haz", 32'(stall_dec_out), 1);
    bypass_in = '0;
    inst_valid_in = 1'b0;
    tick();

    inst_fetched_in = ADDI_X8;
    inst_valid_in = 1'b1;
    tick();
    chk("bp_imm", inst_dec_out.imm, 32'hFFFFFFFF);
    dec_ready_in = 1'b0;
    inst_fetched_in = LUI_X9;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_ready", 32'(inst_ready_out), 0);
      tick();
      chk("bp_valid", 32'(inst_dec_out.valid), 1);
      chk("bp_hold_imm", inst_dec_out.imm, 32'hFFFFFFFF);
      chk("bp_hold_rd", 32'(inst_dec_out.dst_reg), 8);
    end
    dec_ready_in = 1'b1;
    #1 chk("bp_release", 32'(inst_ready_out), 1);
    tick();
    chk("lui_imm", inst_dec_out.imm, 32'h12345000);
    chk("lui_rd", 32'(inst_dec_out.dst_reg), 9);

    inst_fetched_in = ADDI_X8;
    flush_in = 1'b1;
    #1 chk("fl_ready", 32'(inst_ready_out), 0);
    tick();
    chk("fl_valid", 32'(inst_dec_out.valid), 0);
    flush_in = 1'b0;

    inst_fetched_in = ADD_X2;
    bypass_in[0] = byp(5'd1, 1'b0, 32'd0);
    tick();
    chk("fls_state0", 32'(dut.state_q), 32'(STALL));
    flush_in = 1'b1;
    tick();
    chk("fls_valid", 32'(inst_dec_out.valid), 0);
    chk("fls_state", 32'(dut.state_q), 32'(IDLE));
    flush_in = 1'b0;
    bypass_in = '0;

    inst_fetched_in = ADD_X7;
    bypass_in[0] = byp(5'd0, 1'b0, 32'd0);
    #1 chk("x0_stall", 32'(stall_dec_out), 0);
    chk("x0_ready", 32'(inst_ready_out), 1);
    tick();
    chk("x0_valid", 32'(inst_dec_out.valid), 1);
    chk("x0_s1", inst_dec_out.src_data_1, 0);
    chk("end_cnt", stall_cycles_out, 32'(4 * CNT_ON));
    inst_valid_in = 1'b0;
    bypass_in = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
